// File: rtl/lr35902_pkg.sv
// rtl/lr35902_pkg.sv - shared constants and state type for the LR35902 OAM DMA block
package lr35902_pkg;

    localparam logic [7:0]  REG_DMA   = 8'h46;
    localparam logic [15:0] OAM_BASE  = 16'hFE00;
    localparam int          OAM_BYTES = 160;

    typedef enum logic [1:0] {
        IDLE,
        START,
        XFER
    } dma_state_t;

endpackage

// File: rtl/lr35902_oam_dma_if.sv
// rtl/lr35902_oam_dma_if.sv - register, source-bus and OAM write-port signals of the OAM DMA
interface lr35902_oam_dma_if;

    logic [7:0]  reg_adr;
    logic [7:0]  reg_din;
    logic [7:0]  reg_dout;
    logic        reg_read;
    logic        reg_write;
    logic [15:0] dma_adr;
    logic        dma_read;
    logic [7:0]  dma_din;
    logic [7:0]  oam_adr;
    logic [7:0]  oam_dout;
    logic        oam_write;

    // master: CPU register bus and source memory side; slave: the DMA controller
    modport master (
        output reg_adr, reg_din, reg_read, reg_write, dma_din,
        input  reg_dout, dma_adr, dma_read, oam_adr, oam_dout, oam_write
    );

    modport slave (
        input  reg_adr, reg_din, reg_read, reg_write, dma_din,
        output reg_dout, dma_adr, dma_read, oam_adr, oam_dout, oam_write
    );

endinterface

// File: rtl/lr35902_oam_dma.sv
// rtl/lr35902_oam_dma.sv - FF46 OAM DMA controller; optional LR35902_OAM_DMA_SRC_MIRROR_EN echo-RAM source folding
module lr35902_oam_dma #(
    parameter int CYCLES_PER_BYTE = 4,
    parameter int OAM_BYTES       = lr35902_pkg::OAM_BYTES
) (
    input  logic                 clk,
    input  logic                 reset,
    lr35902_oam_dma_if.slave     bus,
    output logic                 busy
);

    import lr35902_pkg::*;

    localparam int              PW         = $clog2(CYCLES_PER_BYTE);
    localparam logic [PW-1:0]   LAST_PHASE = PW'(CYCLES_PER_BYTE - 1);
    localparam logic [7:0]      LAST_IDX   = 8'(OAM_BYTES - 1);

    dma_state_t     state_q, state_d;
    logic [7:0]     src_hi_q, src_hi_d;
    logic [7:0]     idx_q, idx_d;
    logic [PW-1:0]  phase_q, phase_d;
    logic [7:0]     src_issue;
    logic           start_hit;
    logic           last_phase;
    logic           unused_reg_read;

    assign unused_reg_read = bus.reg_read;
    assign start_hit       = bus.reg_write && (bus.reg_adr == REG_DMA);
    assign last_phase      = (phase_q == LAST_PHASE);

`ifdef LR35902_OAM_DMA_SRC_MIRROR_EN
    // Pages E0-FF alias WRAM C0-DF, as the echo region does on the real bus
    assign src_issue = (src_hi_q[7:5] == 3'b111) ? (src_hi_q & 8'hDF) : src_hi_q;
`else
    assign src_issue = src_hi_q;
`endif

    assign bus.reg_dout = (bus.reg_adr == REG_DMA) ? src_hi_q : 8'hFF;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            src_hi_q <= 8'h00;
            idx_q    <= 8'h00;
            phase_q  <= '0;
        end else begin
            state_q  <= state_d;
            src_hi_q <= src_hi_d;
            idx_q    <= idx_d;
            phase_q  <= phase_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        src_hi_d = src_hi_q;
        idx_d    = idx_q;
        phase_d  = phase_q;

        case (state_q)
            START: begin
                if (last_phase) begin
                    state_d = XFER;
                    phase_d = '0;
                    idx_d   = 8'h00;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            XFER: begin
                if (last_phase) begin
                    phase_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = 8'h00;
                    end else begin
                        idx_d = idx_q + 8'h01;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: ;
        endcase

        // A new FF46 write always restarts from the startup M-cycle
        if (start_hit) begin
            src_hi_d = bus.reg_din;
            state_d  = START;
            idx_d    = 8'h00;
            phase_d  = '0;
        end
    end

    always_comb begin
        bus.dma_read  = 1'b0;
        bus.dma_adr   = 16'h0000;
        bus.oam_write = 1'b0;
        bus.oam_adr   = 8'h00;
        bus.oam_dout  = 8'h00;
        busy          = (state_q != IDLE);
        if (state_q == XFER) begin
            bus.dma_read  = 1'b1;
            bus.dma_adr   = {src_issue, idx_q};
            bus.oam_write = last_phase;
            bus.oam_adr   = idx_q;
            bus.oam_dout  = bus.dma_din;
        end
    end

endmodule

// File: tb/tb_lr35902_oam_dma.sv
// tb/tb_lr35902_oam_dma.sv - scoreboard bench for lr35902_oam_dma
module tb_lr35902_oam_dma;

    typedef struct {
        logic [7:0]  oam_adr;
        logic [7:0]  oam_dout;
        logic [15:0] dma_adr;
    } exp_t;

    logic clk;
    logic reset;
    logic busy;
    lr35902_oam_dma_if bus ();

    exp_t sb[$];
    int   tests    = 0;
    int   fails    = 0;
    int   writes   = 0;
    int   busy_cnt = 0;
    int   gaps     = 0;

    lr35902_oam_dma #(.CYCLES_PER_BYTE(4), .OAM_BYTES(160)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .busy  (busy)
    );

    // Source memory returns the low address byte
    assign bus.dma_din = bus.dma_adr[7:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mir(input logic [7:0] s);
`ifdef LR35902_OAM_DMA_SRC_MIRROR_EN
        return (s >= 8'hE0) ? (s - 8'h20) : s;
`else
        return s;
`endif
    endfunction

    task automatic push_xfer(input logic [7:0] src);
        exp_t e;
        for (int i = 0; i < 160; i++) begin
            e.oam_adr  = 8'(i);
            e.oam_dout = 8'(i);
            e.dma_adr  = {mir(src), 8'(i)};
            sb.push_back(e);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [7:0] adr, input logic [7:0] d);
        bus.reg_adr   = adr;
        bus.reg_din   = d;
        bus.reg_write = 1'b1;
        cyc(1);
        bus.reg_write = 1'b0;
    endtask

    task automatic start_dma(input logic [7:0] src);
        push_xfer(src);
        write_reg(8'h46, src);
        busy_cnt = 0;
        writes   = 0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 2000) begin
            cyc(1);
            n++;
        end
        if (n >= 2000) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_writes(input int target);
        int n;
        n = 0;
        while (writes < target && n < 2000) begin
            if (!busy) gaps++;
            cyc(1);
            n++;
        end
        if (n >= 2000) check("writes_timeout", 32'(writes), 32'(target));
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (busy) busy_cnt++;
            if (bus.oam_write) begin
                exp_t e;
                writes++;
                if (sb.size() == 0) begin
                    check("unexpected_oam_write", {24'h0, bus.oam_adr}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("oam_adr",  {24'h0, bus.oam_adr},  {24'h0, e.oam_adr});
                    check("oam_dout", {24'h0, bus.oam_dout}, {24'h0, e.oam_dout});
                    check("dma_adr",  {16'h0, bus.dma_adr},  {16'h0, e.dma_adr});
                    check("dma_read_on_write", {31'h0, bus.dma_read}, 32'd1);
                end
            end
        end
    end

    initial begin
        reset         = 1'b1;
        bus.reg_adr   = 8'h46;
        bus.reg_din   = 8'h00;
        bus.reg_read  = 1'b0;
        bus.reg_write = 1'b0;
        cyc(2);
        check("rst_busy",      {31'h0, busy},          32'd0);
        check("rst_oam_write", {31'h0, bus.oam_write}, 32'd0);
        check("rst_dma_read",  {31'h0, bus.dma_read},  32'd0);
        check("rst_dma_adr",   {16'h0, bus.dma_adr},   32'h0);
        check("rst_oam_adr",   {24'h0, bus.oam_adr},   32'h0);
        check("rst_src_hi",    {24'h0, bus.reg_dout},  32'h0);
        reset = 1'b0;
        cyc(1);

        // Full transfer from page C1
        start_dma(8'hC1);
        wait_idle();
        check("c1_busy_len", 32'(busy_cnt), 32'd644);
        check("c1_writes",   32'(writes),   32'd160);
        check("c1_sb_empty", 32'(sb.size()), 32'd0);

        // Readback, then reset at byte 10
        start_dma(8'h80);
        bus.reg_read = 1'b1;
        bus.reg_adr  = 8'h46;
        #1 check("read_ff46", {24'h0, bus.reg_dout}, 32'h80);
        bus.reg_adr  = 8'h47;
        #1 check("read_ff47", {24'h0, bus.reg_dout}, 32'hFF);
        bus.reg_read = 1'b0;
        bus.reg_adr  = 8'h46;
        wait_writes(10);
        check("pre_reset_writes", 32'(writes), 32'd10);
        reset = 1'b1;
        cyc(1);
        check("mid_rst_busy",      {31'h0, busy},          32'd0);
        check("mid_rst_oam_write", {31'h0, bus.oam_write}, 32'd0);
        check("mid_rst_dma_read",  {31'h0, bus.dma_read},  32'd0);
        reset  = 1'b0;
        sb.delete();
        writes = 0;
        cyc(10);
        check("post_reset_quiet", 32'(writes), 32'd0);

        // Reset beats a same-cycle FF46 write
        reset = 1'b1;
        write_reg(8'h46, 8'h55);
        reset = 1'b0;
        check("rst_win_busy",   {31'h0, busy},         32'd0);
        check("rst_win_src_hi", {24'h0, bus.reg_dout}, 32'h00);
        cyc(8);
        check("rst_win_idle", {31'h0, busy}, 32'd0);

        // Restart at byte 50
        gaps = 0;
        start_dma(8'hC0);
        wait_writes(50);
        check("restart_at",   32'(writes), 32'd50);
        check("restart_gaps", 32'(gaps),   32'd0);
        sb.delete();
        start_dma(8'hD0);
        check("restart_busy", {31'h0, busy}, 32'd1);
        cyc(3);
        check("restart_start_noread", {31'h0, bus.dma_read}, 32'd0);
        cyc(1);
        check("restart_first_read", {31'h0, bus.dma_read}, 32'd1);
        check("restart_first_adr",  {16'h0, bus.dma_adr},  32'hD000);
        wait_idle();
        check("restart_busy_len", 32'(busy_cnt), 32'd644);
        check("restart_writes",   32'(writes),   32'd160);

        // Echo-page source, readback unmodified
        start_dma(8'hFE);
        check("fe_readback", {24'h0, bus.reg_dout}, 32'hFE);
        wait_idle();
        check("fe_writes",   32'(writes),    32'd160);
        check("fe_sb_empty", 32'(sb.size()), 32'd0);
        check("fe_idle_adr", {16'h0, bus.dma_adr}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
